// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the instruction fetch unit
package fetch_pkg;

   // Entry field widths are the widest PC and instruction the fetch unit supports;
   // narrower instances use the low bits and leave the rest zero.
   localparam int unsigned FETCH_PC_W    = 64;
   localparam int unsigned FETCH_INSTR_W = 32;

   // IDLE: nothing outstanding, WAIT: live request outstanding,
   // DRAIN: request outstanding whose response must be thrown away.
   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_WAIT  = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_PC_W-1:0]    pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of fetched {pc, instr} entries
module fetch_queue import fetch_pkg::*; #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  fetch_entry_t           push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // A pop frees the slot a same-cycle push needs, so push into a full queue is legal then.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   // Pointer and occupancy update; flush discards everything, including a same-cycle push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, single-outstanding imem requests, instruction queue
module fetch_unit import fetch_pkg::*; #(
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCSrc_F,
   input  logic [ADDR_W-1:0]  PCBranch_F,
   input  logic               EProc_F,
   input  logic [ADDR_W-1:0]  EVAddr_F,
   output logic               imem_req_F,
   output logic [ADDR_W-1:0]  imem_addr_F,
   input  logic               imem_gnt_F,
   input  logic               imem_rvalid_F,
   input  logic [INSTR_W-1:0] imem_rdata_F,
   output logic [ADDR_W-1:0]  NextPC_F,
   output logic               instr_valid_F,
   output logic [INSTR_W-1:0] instr_F,
   output logic [ADDR_W-1:0]  instr_pc_F,
   input  logic               instr_ready_D
);

   localparam int unsigned       INCR       = INSTR_W / 8;
   localparam int unsigned       OFF_W      = $clog2(INCR);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
   localparam int unsigned       CNT_W      = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] req_pc_q;
   logic              redirect, fire, push, pop;
   logic [ADDR_W-1:0] target;
   logic [CNT_W-1:0]  count;
   fetch_entry_t      entry_d, head;

   // Exception beats branch; targets are forced onto an instruction boundary.
   assign redirect = EProc_F || PCSrc_F;
   assign target   = (EProc_F ? EVAddr_F : PCBranch_F) & ALIGN_MASK;

   // Only issue with a free queue slot reserved for the response; the reset term keeps
   // the request low while reset is held even though the state already reads IDLE.
   assign imem_req_F  = reset && (state_q == FS_IDLE) && !redirect && (count < CNT_W'(DEPTH));
   assign imem_addr_F = pc_q;
   assign fire        = imem_req_F && imem_gnt_F;

   // PC seen by the next edge.
   always_comb begin
      NextPC_F = pc_q;
      if (redirect)  NextPC_F = target;
      else if (fire) NextPC_F = pc_q + ADDR_W'(INCR);
   end

   // Outstanding-request tracking; a response always returns the FSM to IDLE, and a
   // redirect while waiting turns the pending response stale.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FS_IDLE:  if (fire) state_d = FS_WAIT;
         FS_WAIT: begin
            if (imem_rvalid_F) state_d = FS_IDLE;
            else if (redirect) state_d = FS_DRAIN;
         end
         FS_DRAIN: if (imem_rvalid_F) state_d = FS_IDLE;
         default:  state_d = FS_IDLE;
      endcase
   end

   // PC, FSM and address of the request in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FS_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= NextPC_F;
         if (fire) req_pc_q <= pc_q;
      end
   end

   // Only a live response that is not overtaken by a redirect is kept.
   assign push = (state_q == FS_WAIT) && imem_rvalid_F && !redirect;
   assign pop  = instr_valid_F && instr_ready_D;

   // Pack the response with its PC into a queue entry.
   always_comb begin
      entry_d = '0;
      entry_d.pc[ADDR_W-1:0]     = req_pc_q;
      entry_d.instr[INSTR_W-1:0] = imem_rdata_F;
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (push),
      .push_data_i (entry_d),
      .pop_i       (pop),
      .flush_i     (redirect),
      .head_o      (head),
      .count_o     (count)
   );

   assign instr_valid_F = (count != '0);
   assign instr_F       = head.instr[INSTR_W-1:0];
   assign instr_pc_F    = head.pc[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrc_F, EProc_F;
   logic [63:0] PCBranch_F, EVAddr_F;
   logic        imem_req_F, imem_gnt_F, imem_rvalid_F;
   logic [63:0] imem_addr_F, NextPC_F, instr_pc_F;
   logic [31:0] imem_rdata_F, instr_F;
   logic        instr_valid_F, instr_ready_D;
   logic        auto_resp;
   int          n_checks = 0;
   int          n_errors = 0;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .PCSrc_F       (PCSrc_F),
      .PCBranch_F    (PCBranch_F),
      .EProc_F       (EProc_F),
      .EVAddr_F      (EVAddr_F),
      .imem_req_F    (imem_req_F),
      .imem_addr_F   (imem_addr_F),
      .imem_gnt_F    (imem_gnt_F),
      .imem_rvalid_F (imem_rvalid_F),
      .imem_rdata_F  (imem_rdata_F),
      .NextPC_F      (NextPC_F),
      .instr_valid_F (instr_valid_F),
      .instr_F       (instr_F),
      .instr_pc_F    (instr_pc_F),
      .instr_ready_D (instr_ready_D)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk_instr(input logic [63:0] a);
      return 32'hCAFE_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock; the memory model answers one cycle after each grant when auto_resp is set.
   task automatic tick();
      logic        fired;
      logic [63:0] a;
      #1;
      fired = imem_req_F && imem_gnt_F;
      a     = imem_addr_F;
      @(posedge clk);
      #1;
      if (auto_resp) begin
         imem_rvalid_F = fired;
         imem_rdata_F  = fired ? mk_instr(a) : 32'h0;
      end
      #1;
   endtask

   task automatic expect_pop(input string tag, input logic [63:0] exp_pc);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (instr_valid_F && instr_ready_D) begin
            check_val({tag, "_pc"}, instr_pc_F, exp_pc);
            check_val({tag, "_instr"}, 64'(instr_F), 64'(mk_instr(exp_pc)));
            seen = 1'b1;
         end
         tick();
      end
      check_val({tag, "_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      PCSrc_F = 1'b0;
      EProc_F = 1'b0;
      imem_rvalid_F = 1'b0;
      imem_rdata_F = 32'h0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      PCSrc_F = 1'b0;   PCBranch_F = 64'h0;
      EProc_F = 1'b0;   EVAddr_F = 64'h0;
      imem_gnt_F = 1'b1; imem_rvalid_F = 1'b0; imem_rdata_F = 32'h0;
      instr_ready_D = 1'b1;
      auto_resp = 1'b1;

      // Reset state, first request at RESET_PC on the first edge, then in-order delivery.
      @(posedge clk);
      @(negedge clk);
      check_val("rst_req", 64'(imem_req_F), 64'd0);
      check_val("rst_valid", 64'(instr_valid_F), 64'd0);
      check_val("rst_addr", imem_addr_F, 64'h0);
      reset = 1'b1;
      #1;
      check_val("first_req", 64'(imem_req_F), 64'd1);
      check_val("first_addr", imem_addr_F, 64'h0);
      check_val("first_nextpc", NextPC_F, 64'h4);
      tick();
      check_val("wait_req", 64'(imem_req_F), 64'd0);
      check_val("wait_addr", imem_addr_F, 64'h4);
      expect_pop("seq0", 64'h0);
      expect_pop("seq4", 64'h4);
      expect_pop("seq8", 64'h8);

      // Decode stalled: queue fills to two entries and requests stop at PC 0x8.
      do_reset();
      instr_ready_D = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check_val("full_valid", 64'(instr_valid_F), 64'd1);
      check_val("full_head", instr_pc_F, 64'h0);
      check_val("full_req", 64'(imem_req_F), 64'd0);
      check_val("full_addr", imem_addr_F, 64'h8);
      instr_ready_D = 1'b1;
      expect_pop("stall0", 64'h0);
      expect_pop("stall4", 64'h4);
      expect_pop("stall8", 64'h8);

      // Branch while waiting: queue flushed, late response dropped, fetch restarts at 0x1000.
      do_reset();
      auto_resp = 1'b0;
      instr_ready_D = 1'b0;
      tick();
      imem_rvalid_F = 1'b1; imem_rdata_F = 32'h1111_1111;
      tick();
      imem_rvalid_F = 1'b0;
      tick();
      check_val("br_pre_valid", 64'(instr_valid_F), 64'd1);
      PCSrc_F = 1'b1; PCBranch_F = 64'h1002;
      #1;
      check_val("br_nextpc", NextPC_F, 64'h1000);
      check_val("br_req", 64'(imem_req_F), 64'd0);
      tick();
      PCSrc_F = 1'b0;
      #1;
      check_val("drain_valid", 64'(instr_valid_F), 64'd0);
      check_val("drain_req", 64'(imem_req_F), 64'd0);
      imem_rvalid_F = 1'b1; imem_rdata_F = 32'hDEAD_BEEF;
      tick();
      imem_rvalid_F = 1'b0;
      #1;
      check_val("drop_valid", 64'(instr_valid_F), 64'd0);
      check_val("br_req_again", 64'(imem_req_F), 64'd1);
      check_val("br_addr", imem_addr_F, 64'h1000);
      auto_resp = 1'b1;
      instr_ready_D = 1'b1;
      expect_pop("br1000", 64'h1000);

      // Exception and branch together: exception target wins.
      do_reset();
      EProc_F = 1'b1; EVAddr_F = 64'h200;
      PCSrc_F = 1'b1; PCBranch_F = 64'h300;
      #1;
      check_val("exc_nextpc", NextPC_F, 64'h200);
      check_val("exc_req", 64'(imem_req_F), 64'd0);
      tick();
      EProc_F = 1'b0; PCSrc_F = 1'b0;
      #1;
      check_val("exc_addr", imem_addr_F, 64'h200);
      expect_pop("exc200", 64'h200);

      // PC wrap at the top of the address space, then reset while a request is outstanding.
      do_reset();
      instr_ready_D = 1'b0;
      PCSrc_F = 1'b1; PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      PCSrc_F = 1'b0;
      #1;
      check_val("wrap_addr", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
      check_val("wrap_nextpc", NextPC_F, 64'h0);
      tick();
      tick();
      check_val("wrap_head", instr_pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
      check_val("wrap_next_addr", imem_addr_F, 64'h0);
      tick();
      check_val("wrap_wait_addr", imem_addr_F, 64'h4);
      check_val("wrap_q_valid", 64'(instr_valid_F), 64'd1);
      reset = 1'b0;
      #1;
      check_val("arst_req", 64'(imem_req_F), 64'd0);
      check_val("arst_valid", 64'(instr_valid_F), 64'd0);
      check_val("arst_addr", imem_addr_F, 64'h0);
      auto_resp = 1'b0;
      imem_gnt_F = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_val("stray_valid", 64'(instr_valid_F), 64'd0);
      check_val("stray_req", 64'(imem_req_F), 64'd1);
      check_val("stray_addr", imem_addr_F, 64'h0);
      imem_rvalid_F = 1'b0;
      imem_gnt_F = 1'b1;
      auto_resp = 1'b1;
      instr_ready_D = 1'b1;
      expect_pop("post_rst0", 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
